// File: rtl/input_interrupt_queue.sv
// Debounced button event queue. Each debounced press or release becomes an
// "addi $IRQ_REG,$0,code" instruction at the head of a small FIFO.
module input_interrupt_queue #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int IRQ_REG         = 27
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_BUTTONS-1:0]          buttons,
    input  logic                            irq_ack,
    output logic [31:0]                     interrupt_instruction,
    output logic                            irq_pending,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       IRQ_RD     = 5'(IRQ_REG);

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] pend;
    logic [NUM_BUTTONS-1:0] pend_edge;
    logic [CNT_W-1:0]       cnt [NUM_BUTTONS];

    // FIFO entries hold only {edge, idx}; the instruction is rebuilt at the head.
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic       push;
    logic       pop;
    logic       do_write;
    logic [3:0] sel_idx;
    logic       sel_edge;

    always_comb begin
        sel_idx  = 4'd0;
        sel_edge = 1'b0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx  = 4'(i);
                sel_edge = pend_edge[i];
            end
        end
    end

    assign push     = |pend;
    assign pop      = irq_ack && (count != '0);
    assign do_write = push && ((count != FULL_COUNT) || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            pend      <= '0;
            pend_edge <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (push && (sel_idx == 4'(i))) pend[i] <= 1'b0;
                // A fresh debounce event overrides the clear above.
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == LAST_COUNT) begin
                        stable[i]    <= sync2[i];
                        cnt[i]       <= '0;
                        pend[i]      <= 1'b1;
                        pend_edge[i] <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= {sel_edge, sel_idx};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_write) overflow <= 1'b1;
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic [4:0]  head;
    logic [16:0] imm;

    assign head                  = mem[rd_ptr];
    assign imm                   = {11'b0, 1'b1, head[4], head[3:0]};
    assign irq_pending           = (count != '0);
    assign fifo_count            = count;
    assign interrupt_instruction = irq_pending ? {5'b00101, IRQ_RD, 5'd0, imm} : 32'h0;

endmodule

// File: tb/tb_input_interrupt_queue.sv
// Directed bench for input_interrupt_queue: debounce, ordering, overflow,
// full-FIFO push/pop and asynchronous reset.
module tb_input_interrupt_queue;

    logic        clock;
    logic        reset;
    logic [3:0]  buttons;
    logic        irq_ack;
    logic [31:0] interrupt_instruction;
    logic        irq_pending;
    logic [3:0]  fifo_count;
    logic        overflow;

    int tests_run = 0;
    int fails     = 0;

    input_interrupt_queue #(
        .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(16), .CNT_W(16), .FIFO_DEPTH(8), .IRQ_REG(27)
    ) dut (
        .clock(clock),
        .reset(reset),
        .buttons(buttons),
        .irq_ack(irq_ack),
        .interrupt_instruction(interrupt_instruction),
        .irq_pending(irq_pending),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // addi $27,$0,{11'b0,1,edge,idx}
    function automatic logic [31:0] make_instr(input logic edge_lvl, input int idx);
        logic [3:0] id;
        id = 4'(idx);
        return {5'b00101, 5'd27, 5'd0, 11'd0, 1'b1, edge_lvl, id};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        buttons = 4'h0;
        irq_ack = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (interrupt_instruction !== 32'h0 || irq_pending !== 1'b0 ||
            fifo_count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got instr=%h pend=%b cnt=%0d ovf=%b exp all zero",
                     interrupt_instruction, irq_pending, fifo_count, overflow);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        buttons = 4'b0100;
        step(16);
        tests_run++;
        if (irq_pending !== 1'b0) begin
            fails++;
            $display("FAIL press_early got pend=%b exp 0", irq_pending);
        end
        step(4);
        tests_run++;
        if (interrupt_instruction !== 32'h2EC00032) begin
            fails++;
            $display("FAIL press_instr got %h exp %h", interrupt_instruction, 32'h2EC00032);
        end
        tests_run++;
        if (irq_pending !== 1'b1 || fifo_count !== 4'd1) begin
            fails++;
            $display("FAIL press_pending got pend=%b cnt=%0d exp 1/1", irq_pending, fifo_count);
        end
        step(10);
        ack_once();
        tests_run++;
        if (interrupt_instruction !== 32'h0 || irq_pending !== 1'b0 || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL press_ack got instr=%h pend=%b cnt=%0d exp 0/0/0",
                     interrupt_instruction, irq_pending, fifo_count);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        buttons = 4'b0001;
        step(10);
        buttons = 4'b0000;
        step(40);
        tests_run++;
        if (fifo_count !== 4'd0 || interrupt_instruction !== 32'h0) begin
            fails++;
            $display("FAIL glitch got cnt=%0d instr=%h exp 0/0", fifo_count, interrupt_instruction);
        end
    endtask

    task automatic test_empty_ack();
        do_reset();
        ack_once();
        ack_once();
        tests_run++;
        if (fifo_count !== 4'd0 || irq_pending !== 1'b0) begin
            fails++;
            $display("FAIL empty_ack got cnt=%0d pend=%b exp 0/0", fifo_count, irq_pending);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        buttons = 4'b1010;
        step(25);
        tests_run++;
        if (fifo_count !== 4'd2) begin
            fails++;
            $display("FAIL same_cycle_count got %0d exp 2", fifo_count);
        end
        tests_run++;
        if (interrupt_instruction !== make_instr(1'b1, 1)) begin
            fails++;
            $display("FAIL same_cycle_first got %h exp %h", interrupt_instruction, make_instr(1'b1, 1));
        end
        ack_once();
        tests_run++;
        if (interrupt_instruction !== make_instr(1'b1, 3)) begin
            fails++;
            $display("FAIL same_cycle_second got %h exp %h", interrupt_instruction, make_instr(1'b1, 3));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(make_instr(1'b1, i));
        for (int i = 0; i < 4; i++) exp_q.push_back(make_instr(1'b0, i));
        buttons = 4'hF;
        step(25);
        buttons = 4'h0;
        step(25);
        tests_run++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fill_8 got cnt=%0d ovf=%b exp 8/0", fifo_count, overflow);
        end
        buttons = 4'h1;
        step(25);
        tests_run++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_9 got cnt=%0d ovf=%b exp 8/1", fifo_count, overflow);
        end
        for (int k = 0; k < 8; k++) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if (interrupt_instruction !== exp_v) begin
                fails++;
                $display("FAIL drain_%0d got %h exp %h", k, interrupt_instruction, exp_v);
            end
            ack_once();
        end
        tests_run++;
        if (interrupt_instruction !== 32'h0 || fifo_count !== 4'd0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL drained got instr=%h cnt=%0d ovf=%b exp 0/0/1",
                     interrupt_instruction, fifo_count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        do_reset();
        for (int i = 1; i < 4; i++) exp_q.push_back(make_instr(1'b1, i));
        for (int i = 0; i < 4; i++) exp_q.push_back(make_instr(1'b0, i));
        exp_q.push_back(make_instr(1'b1, 0));
        buttons = 4'hF;
        step(25);
        buttons = 4'h0;
        step(25);
        buttons = 4'h1;
        step(18);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(3);
        tests_run++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_push_pop got cnt=%0d ovf=%b exp 8/0", fifo_count, overflow);
        end
        for (int k = 0; k < 8; k++) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if (interrupt_instruction !== exp_v) begin
                fails++;
                $display("FAIL full_drain_%0d got %h exp %h", k, interrupt_instruction, exp_v);
            end
            ack_once();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        buttons = 4'b0111;
        step(25);
        tests_run++;
        if (fifo_count !== 4'd3) begin
            fails++;
            $display("FAIL queued_3 got %0d exp 3", fifo_count);
        end
        buttons = 4'b1111;
        step(8);
        #2;
        reset   = 1'b0;
        buttons = 4'b0000;
        #1;
        tests_run++;
        if (interrupt_instruction !== 32'h0 || irq_pending !== 1'b0 ||
            fifo_count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got instr=%h pend=%b cnt=%0d ovf=%b exp all zero",
                     interrupt_instruction, irq_pending, fifo_count, overflow);
        end
        step(2);
        reset = 1'b1;
        step(40);
        tests_run++;
        if (fifo_count !== 4'd0 || irq_pending !== 1'b0) begin
            fails++;
            $display("FAIL no_stale got cnt=%0d pend=%b exp 0/0", fifo_count, irq_pending);
        end
    endtask

    initial begin
        reset   = 1'b0;
        buttons = 4'h0;
        irq_ack = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_empty_ack();
        test_same_cycle();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
